// File: rtl/prefetch_unit_pkg.sv
// Shared CPU constants and types for the fetch/decode front end.
package prefetch_unit_pkg;

    localparam int WORD_W  = 16;
    localparam int ADDR_W  = 32;
    localparam int LEN_BIT = 15;

    // Instruction length encoding held in bit LEN_BIT of the first word
    typedef enum logic {
        ILEN_16 = 1'b0,
        ILEN_32 = 1'b1
    } ilen_e;

    // One buffered instruction word with the address it was fetched from
    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [ADDR_W-1:0] addr;
    } qentry_t;

    function automatic logic is_long(input logic [WORD_W-1:0] w);
        return w[LEN_BIT] == logic'(ILEN_32);
    endfunction

endpackage

// File: rtl/word_queue.sv
// Circular word buffer: single push, pop of one or two words, clear,
// and a two-entry peek at the head so a 32-bit instruction can be
// assembled even when it straddles the wrap point.
module word_queue
    import prefetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  qentry_t                  push_entry,
    input  logic                     pop1,
    input  logic                     pop2,
    output logic [$clog2(DEPTH):0]   count,
    output qentry_t                  head0,
    output logic [WORD_W-1:0]        head1_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    qentry_t        slots [DEPTH];
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic [PW-1:0]  head_nx;
    logic [1:0]     npop;

    assign npop       = pop2 ? 2'd2 : (pop1 ? 2'd1 : 2'd0);
    assign head_nx    = head + 1'b1;
    assign head0      = slots[head];
    assign head1_data = slots[head_nx].data;

    // Pointer and occupancy update; clear wins over push/pop
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            head  <= head + PW'(npop);
            count <= count + CW'(push) - CW'(npop);
        end
    end

    // Storage write; contents need no reset because count gates use
    always_ff @(posedge clk) begin
        if (push && !clear && !rst) slots[tail] <= push_entry;
    end

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetch: issues 16-bit reads to a 1-cycle instruction
// memory, buffers the returned words, and hands decode one complete
// 16- or 32-bit instruction per cycle. A jump flushes everything and
// restarts fetching at the target.
module prefetch_unit
    import prefetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_rd,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_data,
    input  logic              jump,
    input  logic [ADDR_W-1:0] target,
    input  logic              keep,
    output logic              valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc,
    output logic              extend
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] fpc;
    logic [ADDR_W-1:0] rd_addr;
    logic              inflight;
    logic              drop;
    logic              issue;
    logic              push;
    logic              pop1;
    logic              pop2;
    logic              consume;
    logic              has1;
    logic              has2;
    logic              long_head;
    logic [CW-1:0]     count;
    qentry_t           push_entry;
    qentry_t           h0;
    logic [WORD_W-1:0] h1_data;

    word_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .rst        (rst),
        .clear      (jump),
        .push       (push),
        .push_entry (push_entry),
        .pop1       (pop1),
        .pop2       (pop2),
        .count      (count),
        .head0      (h0),
        .head1_data (h1_data)
    );

    // Issue only when the queue can absorb the outstanding read plus this one
    assign issue      = !rst && !jump && (count + CW'(inflight) < CW'(DEPTH));
    assign imem_rd    = issue;
    assign imem_addr  = fpc;

    assign push       = inflight && !drop;
    assign push_entry = '{data: imem_data, addr: rd_addr};

    assign has1       = count != '0;
    assign has2       = count > CW'(1);
    assign long_head  = is_long(h0.data);

    assign valid      = has1 && (!long_head || has2);
    assign extend     = has1 && long_head;
    assign pc         = has1 ? h0.addr : '0;
    assign instr      = !has1    ? 32'h0 :
                        long_head ? {h0.data, h1_data} : {h0.data, 16'h0};

    // A jump cycle never consumes: the head is about to be flushed
    assign consume    = valid && !keep && !jump;
    assign pop1       = consume && !long_head;
    assign pop2       = consume && long_head;

    // Fetch counter, outstanding-read tracking and redirect handling
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc      <= RESET_PC;
            rd_addr  <= RESET_PC;
            inflight <= 1'b0;
            drop     <= 1'b0;
        end else begin
            inflight <= issue;
            drop     <= jump && inflight;
            if (issue) rd_addr <= fpc;
            if (jump)       fpc <= target;
            else if (issue) fpc <= fpc + 1'b1;
        end
    end

endmodule

// File: tb/tb_prefetch_unit.sv
// Scoreboard bench: the expected instruction stream is derived from the
// memory image by walking it word by word (length from bit 15); a monitor
// pops one expectation each time decode accepts an instruction.
module tb_prefetch_unit;
    import prefetch_unit_pkg::*;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_rd;
    logic [31:0] imem_addr;
    logic [15:0] imem_data = 16'h0;
    logic        jump = 1'b0;
    logic [31:0] target = 32'h0;
    logic        keep = 1'b0;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        extend;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pop   = 0;
    int idle    = 0;
    logic saw_wrap = 1'b0;

    logic [15:0] mem [256];

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        ext;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    always #5 clk = ~clk;

    prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_rd   (imem_rd),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .jump      (jump),
        .target    (target),
        .keep      (keep),
        .valid     (valid),
        .instr     (instr),
        .pc        (pc),
        .extend    (extend)
    );

    // Synchronous instruction memory, one-cycle read latency
    always @(posedge clk) if (imem_rd) imem_data <= mem[imem_addr[7:0]];

    // Expected decode stream starting at a fresh fetch address
    task automatic refill(input logic [31:0] start);
        logic [31:0] p;
        logic [7:0]  a1;
        logic [15:0] w0, w1;
        exp_q.delete();
        p = start;
        for (int i = 0; i < 512; i++) begin
            a1 = p[7:0] + 8'd1;
            w0 = mem[p[7:0]];
            w1 = mem[a1];
            if (w0[15]) begin
                exp_q.push_back('{instr: {w0, w1}, pc: p, ext: 1'b1});
                p = p + 32'd2;
            end else begin
                exp_q.push_back('{instr: {w0, 16'h0}, pc: p, ext: 1'b0});
                p = p + 32'd1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted instruction must be the next one in the stream
    always @(negedge clk) begin
        if (!rst && !jump && valid && !keep) begin
            n_tests++;
            n_pop++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_empty: got pc %h instr %h expected nothing", pc, instr);
            end else begin
                e = exp_q.pop_front();
                if ({instr, pc, extend} !== e) begin
                    n_fail++;
                    $display("FAIL sb_instr: got instr %h pc %h ext %b expected instr %h pc %h ext %b",
                             instr, pc, extend, e.instr, e.pc, e.ext);
                end else if (instr == 32'h8AAABBBB && pc == 32'h63) begin
                    saw_wrap = 1'b1;
                end
            end
        end
        if (rst || jump || valid) idle = 0;
        else idle++;
        if (idle == 12) begin
            n_tests++;
            n_fail++;
            $display("FAIL stall: got %0d idle cycles expected at most 11", idle);
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h0001; mem[1] = 16'h0002; mem[2] = 16'h0003;
        mem[8'h20] = 16'h8ABC; mem[8'h21] = 16'h1234; mem[8'h22] = 16'h0005;
        for (int i = 8'h30; i < 8'h58; i++) mem[i] = mem[i] & 16'h7FFF;
        mem[8'h40] = 16'h0040;
        mem[8'h60] = 16'h0111; mem[8'h61] = 16'h0222; mem[8'h62] = 16'h0333;
        mem[8'h63] = 16'h8AAA; mem[8'h64] = 16'hBBBB;

        // Reset state
        refill(RST_PC);
        rst = 1'b1;
        step(); step(); step();
        chk("rst_valid", 32'(valid), 0);
        chk("rst_rd", 32'(imem_rd), 0);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_instr", instr, 0);
        chk("rst_pc", pc, 0);
        chk("rst_ext", 32'(extend), 0);

        // First fetches after reset release
        rst = 1'b0; #1;
        chk("c0_rd", 32'(imem_rd), 1);
        chk("c0_addr", imem_addr, 0);
        step(); chk("c1_valid", 32'(valid), 0);
        step(); chk("c2_valid", 32'(valid), 1);
        chk("c2_instr", instr, 32'h00010000);
        chk("c2_pc", pc, 0);
        chk("c2_ext", 32'(extend), 0);
        step(); chk("c3_pc", pc, 1);
        chk("c3_instr", instr, 32'h00020000);
        step(); chk("c4_pc", pc, 2);

        // 32-bit instruction after a redirect
        step(); jump = 1'b1; target = 32'h20; refill(32'h20); #1;
        chk("j20_rd", 32'(imem_rd), 0);
        step(); jump = 1'b0; #1;
        chk("j20_t1_valid", 32'(valid), 0);
        step(); step(); chk("j20_t3_valid", 32'(valid), 0);
        step(); chk("j20_t4_valid", 32'(valid), 1);
        chk("j20_instr", instr, 32'h8ABC1234);
        chk("j20_pc", pc, 32'h20);
        chk("j20_ext", 32'(extend), 1);
        step(); chk("j20_next_pc", pc, 32'h22);

        // Decode holds: queue fills and fetch stops
        step(); jump = 1'b1; target = 32'h30; keep = 1'b1; refill(32'h30);
        step(); jump = 1'b0;
        repeat (10) step();
        chk("full_rd", 32'(imem_rd), 0);
        chk("full_fpc", imem_addr, 32'h34);
        chk("full_valid", 32'(valid), 1);
        chk("full_pc", pc, 32'h30);
        chk("full_instr", instr, {mem[8'h30], 16'h0});
        keep = 1'b0;
        repeat (6) step();

        // Redirect with 3 words buffered and one read in flight
        jump = 1'b1; target = 32'h50; keep = 1'b1; refill(32'h50);
        step(); jump = 1'b0;
        repeat (4) step();
        chk("pre_jump_rd", 32'(imem_rd), 0);
        chk("pre_jump_pc", pc, 32'h50);
        jump = 1'b1; target = 32'h40; keep = 1'b0; refill(32'h40); #1;
        chk("jump_rd", 32'(imem_rd), 0);
        step(); jump = 1'b0; #1;
        chk("jump_t1_valid", 32'(valid), 0);
        step(); chk("jump_t2_valid", 32'(valid), 0);
        step(); chk("jump_t3_valid", 32'(valid), 1);
        chk("jump_t3_pc", pc, 32'h40);
        chk("jump_t3_instr", instr, 32'h00400000);

        // 32-bit instruction straddling the queue wrap
        step(); jump = 1'b1; target = 32'h60; refill(32'h60);
        step(); jump = 1'b0;
        repeat (12) step();
        chk("wrap_seen", 32'(saw_wrap), 1);

        // Mid-stream reset
        rst = 1'b1; refill(RST_PC); #1;
        chk("mrst_rd", 32'(imem_rd), 0);
        step(); rst = 1'b0; #1;
        chk("mrst_valid", 32'(valid), 0);
        chk("mrst_ext", 32'(extend), 0);
        chk("mrst_instr", instr, 0);
        chk("mrst_pc", pc, 0);
        chk("mrst_addr", imem_addr, RST_PC);
        chk("mrst_rd1", 32'(imem_rd), 1);
        step(); chk("mrst_t1_valid", 32'(valid), 0);
        step(); chk("mrst_t2_valid", 32'(valid), 1);
        chk("mrst_t2_pc", pc, 0);
        chk("mrst_t2_instr", instr, 32'h00010000);

        // Randomised keep / jump / reset traffic
        repeat (400) begin
            step();
            jump = 1'b0;
            rst  = 1'b0;
            keep = ($urandom_range(0, 99) < 25);
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                refill(RST_PC);
            end else if ($urandom_range(0, 99) < 5) begin
                jump   = 1'b1;
                target = 32'($urandom_range(0, 255));
                refill(target);
            end
        end
        step(); jump = 1'b0; rst = 1'b0; keep = 1'b0;
        repeat (10) step();
        chk("throughput", 32'(n_pop > 150), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prefetch_unit.md
# prefetch_unit

Instruction prefetch stage between the instruction memory and the IF/ID stage register. It streams 16-bit words from a synchronous instruction memory into a small queue. From the queue head it assembles complete 16-bit or 32-bit instructions and presents one per cycle to decode with its PC and length flag. Redirects from the execute-stage branch logic flush all buffered and in-flight words and restart fetching at the target.

## Interface
Parameters:
- DEPTH, 4: queue capacity in 16-bit words; power of two, at least 2.
- RESET_PC, 32'h0: first fetch address after reset, as a word address.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- imem_rd  out  1  read strobe to instruction memory.
- imem_addr  out  32  word address of the read.
- imem_data  in  16  read data, valid the cycle after the strobe.
- jump  in  1  redirect request from branch logic.
- target  in  32  redirect word address, sampled when jump=1.
- keep  in  1  decode is holding; the head instruction is not consumed.
- valid  out  1  a complete instruction is at the head.
- instr  out  32  the instruction: {w0,w1} if 32-bit, {w0,16'h0} if 16-bit.
- pc  out  32  address of w0.
- extend  out  1  1 when the head instruction is 32-bit.

## Operation
- Instruction length is set by w0[15]: 1 means 32-bit (two words), 0 means 16-bit (one word).
- Queue entries are {data[15:0], addr[31:0]}, with a head pointer, a tail pointer and a count of width clog2(DEPTH)+1.
- Fetch counter fpc holds the next address to request.
- Issue rule: imem_rd=1 when count + inflight < DEPTH and jump=0.
  - imem_addr = fpc; fpc increments by 1 per issued read.
  - inflight is a single bit; the memory has a fixed 1-cycle latency, so at most one read is outstanding.
- Response: when inflight=1 and drop=0, push {imem_data, address of that read} at the tail.
- Head output:
  - valid = (count≥1 and w0[15]=0) or (count≥2 and w0[15]=1).
  - instr, pc and extend are driven combinationally from the head entries and are don't-care when valid=0.
- Consume: when valid=1 and keep=0, pop 1 word for a 16-bit instruction or 2 words for a 32-bit one.
- A push and a pop in the same cycle are legal, and count updates by their net difference.
- Jump (highest priority):
  - Clear the queue (count=0, pointers to 0) and set fpc <= target.
  - If a read is in flight, set drop=1 so the next cycle's response is discarded.
  - No read issues in the jump cycle.
  - A pop requested in the same cycle is ignored.
- Pointers wrap modulo DEPTH, so a 32-bit instruction can straddle the wrap.
- Full: when count + inflight == DEPTH, no issue; fpc holds.
- Empty, or a lone 32-bit first half: valid=0, and fetching continues.

## Timing
- Reset values:
  - valid=0, imem_rd=0, extend=0.
  - imem_addr=RESET_PC; instr and pc are 0 while empty.
  - fpc=RESET_PC, count=0, inflight=0, drop=0.
- Fetch starts in the first cycle after rst deasserts.
- Latency:
  - A 16-bit instruction is valid 2 cycles after its read is issued.
  - A 32-bit instruction is valid 3 cycles after its first word's read.
- Redirect: with jump in cycle t, the first read of target issues in t+1 and the target instruction is valid at t+3 at the earliest.
- Steady state with keep=0 sustains one 16-bit instruction per cycle.
- rst asserted mid-operation overrides jump and response, returning to reset values on the next edge; any in-flight data is discarded.

## Structure
- Shared CPU package holds:
  - WORD_W=16, ADDR_W=32.
  - Length-bit index LEN_BIT=15.
  - The instruction-length encoding constants, so decode_unit and this block agree.
- One natural sub-module, `word_queue`: a circular buffer with push, pop1/pop2, clear, count and two-entry head peek.
- Issue and redirect control stay in the top level of prefetch_unit.

## Test plan
- Reset then run, RESET_PC=0, memory with words 0x0001,0x0002,0x0003 at addresses 0–2 → instr=0x00010000 with pc=0, then pc=1 and pc=2, on consecutive cycles from cycle 2 after reset; extend=0.
- 32-bit instruction 0x8ABC,0x1234 at 0–1 → valid with instr=0x8ABC1234, pc=0, extend=1 at cycle 3; the next instruction has pc=2.
- keep held high 10 cycles, DEPTH=4 → imem_rd stops once count reaches 4; fpc=4; outputs stable; on release, words drain in order with no loss or duplication.
- jump=1, target=0x40 while a read is in flight and the queue holds 3 words → valid=0 in t+1; the stale response is not pushed; the first valid pc=0x40 appears at t+3.
- 32-bit instruction placed so w0 sits in slot 3 and w1 in slot 0 (wrap) → correct instr={w0,w1}, pop of 2, count consistent.
- rst asserted for 1 cycle mid-stream with a read in flight → all outputs return to reset values; fetch restarts at RESET_PC; no stale word appears.
